// File: rtl/msg_scroller_pkg.sv
// Shared constants and state encoding for the message scroller.
package msg_scroller_pkg;

  localparam int MSG_CHAR_W = 5;
  localparam int MSG_ADDR_W = 4;
  localparam int MSG_BLANK  = 27;
  localparam int MSG_FIRST  = 1;
  localparam int MSG_LAST   = 15;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_GAP = 1'b1
  } scroll_state_e;

endpackage

// File: rtl/msg_scroller_tick_gen.sv
// Enabled prescaler: one tick every DIV enabled cycles, clearable.
module tick_gen #(
  parameter int DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Tick on the last count of the period, only while enabled.
  assign tick = en && (cnt_q == CNT_MAX);

  // Next count: clear wins, wrap on tick, advance when enabled, else hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/msg_scroller.sv
// Message ROM sequencer: scrolls ROM characters right-to-left through a
// DIGITS-wide window, then scrolls DIGITS blanks before repeating.
module msg_scroller
  import msg_scroller_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int CHAR_W     = MSG_CHAR_W,
  parameter int ADDR_W     = MSG_ADDR_W,
  parameter int DIV        = 25000000,
  parameter int FIRST_ADDR = MSG_FIRST,
  parameter int LAST_ADDR  = MSG_LAST,
  parameter int BLANK      = MSG_BLANK
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     restart,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [CHAR_W-1:0]        rom_data,
  output logic [DIGITS*CHAR_W-1:0] window,
  output logic                     step,
  output logic                     wrap
);

  localparam int GAP_W = $clog2(DIGITS + 1);
  localparam logic [ADDR_W-1:0]        ADDR_FIRST = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0]        ADDR_LAST  = ADDR_W'(LAST_ADDR);
  localparam logic [CHAR_W-1:0]        BLANK_CH   = CHAR_W'(BLANK);
  localparam logic [DIGITS*CHAR_W-1:0] ALL_BLANK  = {DIGITS{BLANK_CH}};

  logic                     tick;
  scroll_state_e            state_q,  state_d;
  logic [ADDR_W-1:0]        addr_q,   addr_d;
  logic [DIGITS*CHAR_W-1:0] window_q, window_d;
  logic [GAP_W-1:0]         gap_q,    gap_d;
  logic                     step_q,   step_d;
  logic                     wrap_q,   wrap_d;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (restart),
    .en   (en),
    .tick (tick)
  );

  // Next state: restart reloads the start-of-message view; a tick shifts
  // either the ROM character (RUN) or a blank (GAP) into the window.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    window_d = window_q;
    gap_d    = gap_q;
    step_d   = 1'b0;
    wrap_d   = 1'b0;
    if (restart) begin
      state_d  = ST_RUN;
      addr_d   = ADDR_FIRST;
      window_d = ALL_BLANK;
      gap_d    = '0;
    end else if (tick) begin
      step_d = 1'b1;
      case (state_q)
        ST_RUN: begin
          window_d = {window_q[(DIGITS-1)*CHAR_W-1:0], rom_data};
          if (addr_q == ADDR_LAST) begin
            addr_d  = ADDR_FIRST;
            wrap_d  = 1'b1;
            gap_d   = GAP_W'(DIGITS);
            state_d = ST_GAP;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
          end
        end
        ST_GAP: begin
          window_d = {window_q[(DIGITS-1)*CHAR_W-1:0], BLANK_CH};
          gap_d    = gap_q - GAP_W'(1);
          if (gap_q == GAP_W'(1)) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_GAP;
          end
        end
        default: begin
          state_d = ST_RUN;
          addr_d  = ADDR_FIRST;
          gap_d   = '0;
        end
      endcase
    end else begin
      step_d = 1'b0;
      wrap_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      addr_q   <= ADDR_FIRST;
      window_q <= ALL_BLANK;
      gap_q    <= '0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      window_q <= window_d;
      gap_q    <= gap_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
    end
  end

  assign rom_addr = addr_q;
  assign window   = window_q;
  assign step     = step_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_msg_scroller.sv
// Bench: three scrollers (DIV = 1, 2, 3) share a random ROM image and common
// controls; each is compared every cycle with a sequence-position model.
module tb_msg_scroller;

  localparam int NI     = 3;
  localparam int DIGITS = 4;
  localparam int FIRST  = 1;
  localparam int NMSG   = 15;
  localparam int SEQLEN = NMSG + DIGITS;
  localparam logic [19:0] ALLB = {4{5'd27}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic restart = 1'b0;

  logic [4:0]  rom [16];
  logic [3:0]  addr [NI];
  logic [4:0]  rdat [NI];
  logic [19:0] win  [NI];
  logic        stp  [NI];
  logic        wrp  [NI];

  int div_of [NI] = '{1, 2, 3};
  int m_cnt  [NI];
  int m_pos  [NI];
  logic [19:0] m_win [NI];
  logic        m_step [NI];
  logic        m_wrap [NI];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rdat[0] = rom[addr[0]];
  assign rdat[1] = rom[addr[1]];
  assign rdat[2] = rom[addr[2]];

  msg_scroller #(.DIGITS(4), .DIV(1)) dut0 (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .rom_addr(addr[0]), .rom_data(rdat[0]), .window(win[0]),
    .step(stp[0]), .wrap(wrp[0]));
  msg_scroller #(.DIGITS(4), .DIV(2)) dut1 (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .rom_addr(addr[1]), .rom_data(rdat[1]), .window(win[1]),
    .step(stp[1]), .wrap(wrp[1]));
  msg_scroller #(.DIGITS(4), .DIV(3)) dut2 (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .rom_addr(addr[2]), .rom_data(rdat[2]), .window(win[2]),
    .step(stp[2]), .wrap(wrp[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_addr(input int k);
    return (m_pos[k] < NMSG) ? 4'(FIRST + m_pos[k]) : 4'(FIRST);
  endfunction

  // Advance the model by one clock edge using the current control inputs.
  task automatic model_edge();
    logic [4:0] ch;
    for (int k = 0; k < NI; k++) begin
      m_step[k] = 1'b0;
      m_wrap[k] = 1'b0;
      if (rst || restart) begin
        m_cnt[k] = 0;
        m_pos[k] = 0;
        m_win[k] = ALLB;
      end else if (en) begin
        if (m_cnt[k] == div_of[k] - 1) begin
          m_cnt[k] = 0;
          ch = (m_pos[k] < NMSG) ? rom[FIRST + m_pos[k]] : 5'd27;
          m_win[k] = {m_win[k][14:0], ch};
          m_step[k] = 1'b1;
          m_wrap[k] = (m_pos[k] == NMSG - 1);
          m_pos[k] = (m_pos[k] + 1) % SEQLEN;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("win%0d", k), 32'(win[k]), 32'(m_win[k]));
      check($sformatf("addr%0d", k), 32'(addr[k]), 32'(m_addr(k)));
      check($sformatf("step%0d", k), 32'(stp[k]), 32'(m_step[k]));
      check($sformatf("wrap%0d", k), 32'(wrp[k]), 32'(m_wrap[k]));
    end
  endtask

  initial begin
    int guard;
    for (int a = 0; a < 16; a++) rom[a] = 5'($urandom_range(0, 31));
    rom[1] = 5'd19; rom[2] = 5'd24; rom[3] = 5'd11; rom[4] = 5'd19;
    rom[15] = 5'd27;

    // Reset for three cycles, then first cycle out of reset.
    rst = 1'b1; en = 1'b1;
    repeat (3) cycle();
    check("rst_addr", 32'(addr[1]), 32'd1);
    check("rst_win", 32'(win[1]), 32'(ALLB));
    rst = 1'b0;

    // First characters at DIV=2: four shifts in eight cycles.
    repeat (8) cycle();
    check("first_win", 32'(win[1]), 32'({5'd19, 5'd24, 5'd11, 5'd19}));
    check("first_addr", 32'(addr[1]), 32'd5);

    // Run the DIV=1 instance through wrap and the blank gap.
    guard = 0;
    while (!(m_pos[0] == 0 && m_step[0]) && guard < 200) begin
      cycle(); guard++;
    end
    check("gap_bound", 32'(guard < 200), 32'd1);
    check("gap_allblank", 32'(win[0]), 32'(ALLB));
    cycle();
    check("after_gap_ch", 32'(win[0][4:0]), 32'd19);

    // Pause mid-count on the DIV=3 instance.
    guard = 0;
    while (m_cnt[2] != 1 && guard < 10) begin
      cycle(); guard++;
    end
    en = 1'b0;
    repeat (10) begin
      cycle();
      check("pause_step", 32'(stp[2]), 32'd0);
    end
    en = 1'b1;
    repeat (4) cycle();

    // Restart colliding with a tick at address 9 on the DIV=1 instance.
    guard = 0;
    while (m_addr(0) != 4'd9 && guard < 200) begin
      cycle(); guard++;
    end
    check("restart_bound", 32'(guard < 200), 32'd1);
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    check("restart_addr", 32'(addr[0]), 32'd1);
    check("restart_win", 32'(win[0]), 32'(ALLB));
    check("restart_step", 32'(stp[0]), 32'd0);
    cycle();
    check("restart_next", 32'(win[0][4:0]), 32'd19);

    // Reset after two of the four gap blanks.
    guard = 0;
    while (m_pos[0] != NMSG + 2 && guard < 200) begin
      cycle(); guard++;
    end
    check("gaprst_bound", 32'(guard < 200), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("gaprst_addr", 32'(addr[0]), 32'd1);
    check("gaprst_win", 32'(win[0]), 32'(ALLB));
    cycle();
    check("gaprst_c1", 32'(win[0][4:0]), 32'd19);
    cycle();
    check("gaprst_c2", 32'(win[0][4:0]), 32'd24);

    // Randomized controls.
    for (int i = 0; i < 1500; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      restart = ($urandom_range(0, 199) == 0);
      rst     = ($urandom_range(0, 499) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
